sram_arbiter: RTL and testbench

- Shares the single byte-wide SRAM access port (address/indata/outdata/load/store) between two requesters.
- Requester A is the CPU bus; requester B is the video/DMA fetch path.
- Sequences each access as a fixed-length load or store strobe and returns read data with a one-cycle ack pulse.
- Sits between the requesters and the sram block, in the clock4 domain. Grants are blocked while prog is high, so UART programming owns the RAM.

---
 rtl/sram_arbiter_pkg.sv | 16 +
 rtl/sram_arbiter_rr_pick2.sv | 23 ++
 rtl/sram_arbiter.sv | 113 +++++++++++
 tb/tb_sram_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter: FSM states, requester ids and counter width.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Wide enough for the largest legal strobe length (15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/sram_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright; on a tie the side
// that was not granted last wins.
module rr_pick2
    import sram_arbiter_pkg::*;
(
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_last,
    output logic o_valid,
    output logic o_winner
);

    assign o_valid = i_req_a | i_req_b;

    always_comb begin
        o_winner = REQ_A;
        if (i_req_a && i_req_b)
            o_winner = ~i_last;
        else if (i_req_b)
            o_winner = REQ_B;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single SRAM port between the CPU bus (A) and the video/DMA path (B),
// running each access as a fixed-length strobe followed by a one-cycle ack.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clock4,
    input  logic              resetn,
    input  logic              prog,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_indata,
    input  logic [DATA_W-1:0] mem_outdata,
    output logic              mem_load,
    output logic              mem_store
);

    state_t            r_state, w_next;
    logic              r_last, r_winner;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata_a, r_rdata_b;
    logic              r_load, r_store, r_ack_a, r_ack_b;
    logic              w_valid, w_winner, w_grant, w_last_cyc;

    rr_pick2 u_pick (
        .i_req_a  (a_req),
        .i_req_b  (b_req),
        .i_last   (r_last),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    assign w_grant    = (r_state == IDLE) && !prog && w_valid;
    assign w_last_cyc = (r_state == ACCESS) && (r_cnt == '0);

    always_ff @(posedge clock4 or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant)    w_next = ACCESS;
            ACCESS:  if (w_last_cyc) w_next = DONE;
            DONE:                    w_next = IDLE;
            default:                 w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock4 or negedge resetn) begin
        if (!resetn) begin
            r_last    <= REQ_B;
            r_winner  <= REQ_A;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_load    <= 1'b0;
            r_store   <= 1'b0;
            r_ack_a   <= 1'b0;
            r_ack_b   <= 1'b0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
            if (w_grant) begin
                r_addr   <= (w_winner == REQ_B) ? b_addr  : a_addr;
                r_wdata  <= (w_winner == REQ_B) ? b_wdata : a_wdata;
                r_load   <= (w_winner == REQ_B) ? ~b_we   : ~a_we;
                r_store  <= (w_winner == REQ_B) ? b_we    : a_we;
                r_cnt    <= CNT_W'(ACCESS_CYCLES - 1);
                r_last   <= w_winner;
                r_winner <= w_winner;
            end else if (w_last_cyc) begin
                // Ack is registered here so it is high for exactly the DONE cycle.
                if (r_load && r_winner == REQ_A) r_rdata_a <= mem_outdata;
                if (r_load && r_winner == REQ_B) r_rdata_b <= mem_outdata;
                r_ack_a <= (r_winner == REQ_A);
                r_ack_b <= (r_winner == REQ_B);
                r_load  <= 1'b0;
                r_store <= 1'b0;
            end else if (r_state == ACCESS) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign mem_address = r_addr;
    assign mem_indata  = r_wdata;
    assign mem_load    = r_load;
    assign mem_store   = r_store;
    assign a_ack       = r_ack_a;
    assign b_ack       = r_ack_b;
    assign a_rdata     = r_rdata_a;
    assign b_rdata     = r_rdata_b;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a 2-cycle build against a registered-read SRAM
// model, plus a 4-cycle build whose read data changes every strobe cycle.
module tb_sram_arbiter;

    logic        clock4 = 1'b0;
    logic        resetn, prog;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_ack, b_ack, mem_load, mem_store;
    logic [7:0]  a_rdata, b_rdata, mem_indata, mem_outdata;
    logic [15:0] mem_address;
    logic [7:0]  mem [256];

    logic        a4_req;
    logic [15:0] a4_addr;
    logic        a4_ack, b4_ack, load4, store4;
    logic [7:0]  a4_rdata, b4_rdata, indata4, outdata4, cnt4;
    logic [15:0] addr4;

    int n_tests = 0, n_fail = 0;
    int n_ld, n_st, n_both, n_rise, n_long, n_aack, n_back, n_ld4;
    logic       p_stb, p_aack, p_back;
    logic [7:0] ord;

    always #5 clock4 = ~clock4;

    sram_arbiter #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(2)) u0 (
        .clock4(clock4), .resetn(resetn), .prog(prog),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_indata(mem_indata), .mem_outdata(mem_outdata),
        .mem_load(mem_load), .mem_store(mem_store)
    );

    sram_arbiter #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(4)) u4 (
        .clock4(clock4), .resetn(resetn), .prog(1'b0),
        .a_req(a4_req), .a_we(1'b0), .a_addr(a4_addr), .a_wdata(8'h00),
        .a_ack(a4_ack), .a_rdata(a4_rdata),
        .b_req(1'b0), .b_we(1'b0), .b_addr(16'h0000), .b_wdata(8'h00),
        .b_ack(b4_ack), .b_rdata(b4_rdata),
        .mem_address(addr4), .mem_indata(indata4), .mem_outdata(outdata4),
        .mem_load(load4), .mem_store(store4)
    );

    // Registered-read SRAM, indexed by the low address byte.
    always @(posedge clock4) begin
        mem_outdata <= mem[mem_address[7:0]];
        if (mem_store) mem[mem_address[7:0]] <= mem_indata;
    end

    // Read data for the 4-cycle build steps A0, A1, ... through the strobe.
    always @(posedge clock4) cnt4 <= load4 ? cnt4 + 8'd1 : 8'd0;
    assign outdata4 = 8'hA0 + cnt4;

    always @(negedge clock4) begin
        if (mem_load)  n_ld++;
        if (mem_store) n_st++;
        if (mem_load && mem_store) n_both++;
        if ((mem_load || mem_store) && !p_stb) n_rise++;
        if ((a_ack && p_aack) || (b_ack && p_back)) n_long++;
        if (a_ack) begin n_aack++; ord = {ord[5:0], 2'b01}; end
        if (b_ack) begin n_back++; ord = {ord[5:0], 2'b10}; end
        if (load4) n_ld4++;
        p_stb  = mem_load || mem_store;
        p_aack = a_ack;
        p_back = b_ack;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock4);
        #1;
    endtask

    task automatic clr();
        n_ld = 0; n_st = 0; n_both = 0; n_rise = 0; n_long = 0;
        n_aack = 0; n_back = 0; n_ld4 = 0; ord = '0;
    endtask

    initial begin
        p_stb = 0; p_aack = 0; p_back = 0; cnt4 = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h50] = 8'hCE; mem[8'h01] = 8'h11; mem[8'h02] = 8'h22;
        resetn = 1; prog = 0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        a4_req = 0; a4_addr = 0;
        clr();
        #2 resetn = 0;
        tick(); tick();
        chk("rst_addr",  mem_address, 16'h0000);
        chk("rst_strb",  {mem_load, mem_store, a_ack, b_ack}, 4'b0000);
        chk("rst_rdata", {a_rdata, b_rdata, mem_indata}, 24'h000000);
        resetn = 1;
        tick();

        // Single A load
        clr();
        a_req = 1; a_we = 0; a_addr = 16'h0150;
        tick();
        chk("ld_strobe", mem_load, 1'b1);
        chk("ld_addr",   mem_address, 16'h0150);
        tick();
        chk("ld_hold",   {mem_load, a_ack}, 2'b10);
        tick();
        chk("ld_ack",    {mem_load, a_ack}, 2'b01);
        chk("ld_rdata",  a_rdata, 8'hCE);
        a_req = 0;
        tick();
        chk("ld_ack_end", a_ack, 1'b0);
        chk("ld_ncyc",   n_ld, 2);
        chk("ld_no_back", n_back, 0);

        // Single B store
        clr();
        b_req = 1; b_we = 1; b_addr = 16'h8000; b_wdata = 8'h5A;
        tick();
        chk("st_strobe", {mem_store, mem_load}, 2'b10);
        chk("st_data",   {mem_address, mem_indata}, {16'h8000, 8'h5A});
        tick(); tick();
        chk("st_ack",    {mem_store, b_ack}, 2'b01);
        chk("st_rdata",  {a_rdata, b_rdata}, {8'hCE, 8'h00});
        b_req = 0;
        tick();
        chk("st_ncyc",   {n_st[7:0], n_ld[7:0]}, 16'h0200);
        chk("st_mem",    mem[8'h00], 8'h5A);

        // Contention: four back-to-back accesses alternate A,B,A,B
        clr();
        a_req = 1; a_we = 0; a_addr = 16'h0001;
        b_req = 1; b_we = 0; b_addr = 16'h0002;
        for (int i = 0; i < 16; i++) tick();
        a_req = 0; b_req = 0;
        tick(); tick();
        chk("rr_order",  ord, 8'h66);
        chk("rr_acks",   {n_aack[7:0], n_back[7:0]}, 16'h0202);
        chk("rr_pulse",  n_long, 0);
        chk("rr_overlap", n_both, 0);
        chk("rr_rises",  n_rise, 4);
        chk("rr_rdata",  {a_rdata, b_rdata}, {8'h11, 8'h22});

        // prog raised mid-access: access completes, then grants are held off
        clr();
        a_req = 1; a_we = 0; a_addr = 16'h0150;
        tick();
        chk("pg_grant",  mem_load, 1'b1);
        prog = 1;
        tick(); tick();
        chk("pg_ack",    a_ack, 1'b1);
        chk("pg_rdata",  a_rdata, 8'hCE);
        a_req = 0; b_req = 1; b_we = 0; b_addr = 16'h0002;
        tick(); tick(); tick();
        chk("pg_blocked", {mem_load, n_back[7:0]}, 9'h000);
        prog = 0;
        tick();
        chk("pg_b_grant", {mem_load, mem_address}, {1'b1, 16'h0002});
        tick(); tick();
        chk("pg_b_ack",  {b_ack, b_rdata}, {1'b1, 8'h22});
        b_req = 0;
        tick();

        // Reset in the middle of an A store
        a_req = 1; a_we = 1; a_addr = 16'h0003; a_wdata = 8'h77;
        tick();
        chk("rs_strobe", mem_store, 1'b1);
        #2 resetn = 0;
        #1;
        chk("rs_async",  {mem_store, mem_load, a_ack, b_ack}, 4'b0000);
        chk("rs_vals",   {mem_address, a_rdata, b_rdata}, 32'h0);
        tick();
        resetn = 1;
        tick();
        chk("rs_reissue", {mem_store, mem_address, mem_indata}, {1'b1, 16'h0003, 8'h77});
        tick(); tick();
        chk("rs_ack",    a_ack, 1'b1);
        chk("rs_mem",    mem[8'h03], 8'h77);
        a_req = 0;
        tick();

        // 4-cycle build: strobe held 4 cycles, data from the 4th strobe cycle
        clr();
        a4_req = 1; a4_addr = 16'h0010;
        tick();
        chk("ac4_grant", {load4, addr4}, {1'b1, 16'h0010});
        tick(); tick(); tick();
        chk("ac4_hold",  {load4, a4_ack}, 2'b10);
        tick();
        chk("ac4_ack",   {load4, a4_ack}, 2'b01);
        chk("ac4_rdata", a4_rdata, 8'hA3);
        a4_req = 0;
        tick();
        chk("ac4_ncyc",  n_ld4, 4);
        chk("ac4_ack_end", a4_ack, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
